// File: rtl/cache_req_arbiter_pkg.sv
// Shared types and field positions for the two-processor cache request front end.
package cache_pkg;
  localparam int REQ_W    = 22;
  localparam int PID_BIT  = 21;
  localparam int LS_BIT   = 20;
  localparam int TAG_MSB  = 19;
  localparam int TAG_LSB  = 9;
  localparam int OFF_BIT  = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef logic [REQ_W-1:0] req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} out_state_t;
endpackage

// File: rtl/cache_req_arbiter_if.sv
// Processor-side and cache-side handshake bundle for cache_req_arbiter.
interface cache_req_arbiter_if
  import cache_pkg::*;
#(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          p0_valid;
  req_t          p0_request;
  logic          p0_ready;
  logic          p1_valid;
  req_t          p1_request;
  logic          p1_ready;
  logic          cache_busy;
  logic          cache_valid;
  req_t          cache_request;
  logic [LW-1:0] p0_level;
  logic [LW-1:0] p1_level;

  modport slave (
    input  p0_valid, p0_request, p1_valid, p1_request, cache_busy,
    output p0_ready, p1_ready, cache_valid, cache_request, p0_level, p1_level
  );

  modport master (
    output p0_valid, p0_request, p1_valid, p1_request, cache_busy,
    input  p0_ready, p1_ready, cache_valid, cache_request, p0_level, p1_level
  );
endinterface

// File: rtl/cache_req_arbiter_req_fifo.sv
// Per-port request FIFO; push/pop are ignored when full/empty respectively.
module req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  req_t          i_data,
  input  logic          i_pop,
  output req_t          o_data,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);
  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic          w_push, w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rd];
  assign o_level = r_level;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end
endmodule

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter and registered output stage for two processor request FIFOs.
// Define CACHE_REQ_ZIDLE_EN to float cache_request while cache_valid is low.
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_req_arbiter_if.slave   bus
);
  logic [1:0]         w_push, w_pop, w_full, w_empty;
  req_t [1:0]         w_in, w_data;
  logic [1:0][LW-1:0] w_level;
  logic               w_any, w_sel, w_do_pop;
  req_t               w_issue;

  out_state_t r_state;
  logic       r_valid, r_last;
  req_t       r_req;

  assign w_push = {bus.p1_valid, bus.p0_valid};
  assign w_in   = {bus.p1_request, bus.p0_request};

  for (genvar g = 0; g < 2; g++) begin : g_port
    req_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push[g]),
      .i_data  (w_in[g]),
      .i_pop   (w_pop[g]),
      .o_data  (w_data[g]),
      .o_level (w_level[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign bus.p0_ready = ~w_full[0];
  assign bus.p1_ready = ~w_full[1];
  assign bus.p0_level = w_level[0];
  assign bus.p1_level = w_level[1];

  // On a tie the port not granted last wins; otherwise the only non-empty one.
  assign w_any    = ~&w_empty;
  assign w_sel    = (~w_empty[0] & ~w_empty[1]) ? ~r_last : w_empty[0];
  assign w_do_pop = ~bus.cache_busy & w_any;
  assign w_pop    = w_do_pop ? (w_sel ? 2'b10 : 2'b01) : 2'b00;

  always_comb begin
    w_issue          = w_data[w_sel];
    w_issue[PID_BIT] = w_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_req   <= '0;
      r_last  <= 1'b1;
    end else if (bus.cache_busy) begin
      if (r_state == ISSUE) r_state <= HOLD;
    end else if (w_any) begin
      r_state <= ISSUE;
      r_valid <= 1'b1;
      r_req   <= w_issue;
      r_last  <= w_sel;
    end else begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_req   <= '0;
    end
  end

  assign bus.cache_valid = r_valid;
`ifdef CACHE_REQ_ZIDLE_EN
  assign bus.cache_request = r_valid ? r_req : 'z;
`else
  assign bus.cache_request = r_req;
`endif
endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: ordering, busy hold, full FIFO, mid-run reset.
module tb_cache_req_arbiter;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cache_req_arbiter_if #(.DEPTH(4)) bus();

  cache_req_arbiter #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef CACHE_REQ_ZIDLE_EN
  localparam req_t IDLE_REQ = 22'bz;
`else
  localparam req_t IDLE_REQ = 22'h000000;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input req_t d0, input logic v1, input req_t d1);
    bus.p0_valid   = v0;
    bus.p0_request = d0;
    bus.p1_valid   = v1;
    bus.p1_request = d1;
  endtask

  task automatic chk_out(input string tag, input logic v, input req_t r);
    chk({tag, "_valid"}, 32'(bus.cache_valid), 32'(v));
    chk({tag, "_req"},   32'(bus.cache_request), 32'(r));
  endtask

  task automatic chk_reset(input string tag);
    chk_out(tag, 1'b0, IDLE_REQ);
    chk({tag, "_lvl0"}, 32'(bus.p0_level), 32'd0);
    chk({tag, "_lvl1"}, 32'(bus.p1_level), 32'd0);
    chk({tag, "_rdy0"}, 32'(bus.p0_ready), 32'd1);
    chk({tag, "_rdy1"}, 32'(bus.p1_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    req_t exp3 [6];
    exp3 = '{22'h000010, 22'h200020, 22'h000011, 22'h200021, 22'h000012, 22'h200022};

    rst_n = 1'b0;
    bus.cache_busy = 1'b0;
    drive(0, '0, 0, '0);
    #3;
    chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    tick();

    // single load from p0: one-cycle latency from empty
    drive(1, 22'h050000, 0, '0);
    tick();
    drive(0, '0, 0, '0);
    chk("t1_lvl", 32'(bus.p0_level), 32'd1);
    chk_out("t1_pre", 0, IDLE_REQ);
    tick();
    chk_out("t1_iss", 1, 22'h050000);
    tick();
    chk_out("t1_idle", 0, IDLE_REQ);

    // p1 store gets id bit forced to 1
    drive(0, '0, 1, 22'h1502AB);
    tick();
    drive(0, '0, 0, '0);
    tick();
    chk_out("t2_iss", 1, 22'h3502AB);
    tick();

    // both saturated: alternate starting with p0
    for (int c = 0; c < 7; c++) begin
      if (c < 3) drive(1, req_t'(22'h000010 + c), 1, req_t'(22'h000020 + c));
      else       drive(0, '0, 0, '0);
      tick();
      if (c >= 1) chk_out($sformatf("t3_%0d", c - 1), 1, exp3[c-1]);
    end
    drive(0, '0, 0, '0);
    tick();
    chk_out("t3_idle", 0, IDLE_REQ);

    // busy hold for 3 cycles
    drive(1, 22'h050000, 0, '0);
    tick();
    drive(1, 22'h050001, 0, '0);
    tick();
    drive(0, '0, 0, '0);
    chk_out("t4_iss", 1, 22'h050000);
    bus.cache_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("t4_hold%0d", k), 1, 22'h050000);
      chk($sformatf("t4_lvl%0d", k), 32'(bus.p0_level), 32'd1);
    end
    bus.cache_busy = 1'b0;
    tick();
    chk_out("t4_next", 1, 22'h050001);
    tick();
    chk_out("t4_idle", 0, IDLE_REQ);

    // fill p0 under busy; fifth push refused
    bus.cache_busy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, req_t'(22'h000100 + k), 0, '0);
      tick();
      chk($sformatf("t5_lvl%0d", k), 32'(bus.p0_level), (k < 4) ? 32'(k + 1) : 32'd4);
      chk($sformatf("t5_rdy%0d", k), 32'(bus.p0_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    drive(0, '0, 0, '0);
    chk_out("t5_busy_idle", 0, IDLE_REQ);
    bus.cache_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("t5_iss%0d", k), 1, req_t'(22'h000100 + k));
      chk($sformatf("t5_dlvl%0d", k), 32'(bus.p0_level), 32'(3 - k));
    end
    tick();
    chk_out("t5_idle", 0, IDLE_REQ);

    // mid-run reset with 2 entries queued per port and a held request
    drive(1, 22'h0000AA, 0, '0);
    tick();
    drive(1, 22'h0000B0, 1, 22'h0000C0);
    tick();
    chk_out("t6_iss", 1, 22'h0000AA);
    bus.cache_busy = 1'b1;
    drive(1, 22'h0000B1, 1, 22'h0000C1);
    tick();
    drive(0, '0, 0, '0);
    chk("t6_lvl0", 32'(bus.p0_level), 32'd2);
    chk("t6_lvl1", 32'(bus.p1_level), 32'd2);
    chk_out("t6_hold", 1, 22'h0000AA);
    #2 rst_n = 1'b0;
    #1;
    chk_reset("t6_rst");
    @(negedge clk) rst_n = 1'b1;
    bus.cache_busy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("t6_post%0d", k), 0, IDLE_REQ);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
